// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice processes a WIDTH-bit operand pair LSB first,
// with carry chaining, subtract setup, SLT fix-up, flag generation and Start/Busy/Done handshake.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       AluOp,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, res_sh_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r, cin_msb_r, sum_msb_r;
  logic             busy_r, done_r, cout_r, ovf_r, zero_r;
  logic [WIDTH-1:0] result_r;
  logic [1:0]       slice_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_cout_s, fin_ovf_s, ovf_s;

  // One ALU slice; returns {carry_out, result_bit}. Illegal ops yield zero.
  function automatic logic [1:0] alu_slice(input logic a, input logic b, input logic cin,
                                           input logic [2:0] op);
    logic bb;
    bb = ((op == OP_SUB) || (op == OP_SLT)) ? ~b : b;
    case (op)
      OP_AND:                 alu_slice = {1'b0, a & b};
      OP_OR:                  alu_slice = {1'b0, a | b};
      OP_XOR:                 alu_slice = {1'b0, a ^ b};
      OP_ADD, OP_SUB, OP_SLT: alu_slice = {(a & bb) | (cin & (a ^ bb)), a ^ bb ^ cin};
      default:                alu_slice = 2'b00;
    endcase
  endfunction

  // State register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state_r <= S_IDLE;
    else         state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start) next_state_s = S_RUN;
        else       next_state_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == LAST_BIT) next_state_s = S_FINISH;
        else                   next_state_s = S_RUN;
      end
      S_FINISH: next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Current slice evaluation and final result/flag selection.
  always_comb begin
    slice_s    = alu_slice(a_sh_r[0], b_sh_r[0], carry_r, op_r);
    ovf_s      = cin_msb_r ^ carry_r;
    fin_res_s  = {WIDTH{1'b0}};
    fin_cout_s = 1'b0;
    fin_ovf_s  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        fin_res_s  = res_sh_r;
        fin_cout_s = carry_r;
        fin_ovf_s  = ovf_s;
      end
      // Signed less-than: sign of the difference corrected by overflow.
      OP_SLT: begin
        fin_res_s  = {{(WIDTH-1){1'b0}}, sum_msb_r ^ ovf_s};
        fin_cout_s = carry_r;
        fin_ovf_s  = ovf_s;
      end
      OP_AND, OP_OR, OP_XOR: begin
        fin_res_s  = res_sh_r;
        fin_cout_s = 1'b0;
        fin_ovf_s  = 1'b0;
      end
      default: begin
        fin_res_s  = {WIDTH{1'b0}};
        fin_cout_s = 1'b0;
        fin_ovf_s  = 1'b0;
      end
    endcase
  end

  // Operand capture, serial datapath and registered outputs.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      res_sh_r  <= {WIDTH{1'b0}};
      op_r      <= 3'b000;
      cnt_r     <= {CW{1'b0}};
      carry_r   <= 1'b0;
      cin_msb_r <= 1'b0;
      sum_msb_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            op_r    <= AluOp;
            carry_r <= ((AluOp == OP_SUB) || (AluOp == OP_SLT)) ? 1'b1 : 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_RUN: begin
          res_sh_r <= {slice_s[0], res_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= slice_s[1];
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
            cin_msb_r <= carry_r;
            sum_msb_r <= slice_s[0];
          end else begin
            cin_msb_r <= cin_msb_r;
            sum_msb_r <= sum_msb_r;
          end
        end
        S_FINISH: begin
          result_r <= fin_res_s;
          cout_r   <= fin_cout_s;
          ovf_r    <= fin_ovf_s;
          zero_r   <= (fin_res_s == {WIDTH{1'b0}});
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Result   = result_r;
  assign CarryOut = cout_r;
  assign Overflow = ovf_r;
  assign Zero     = zero_r;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: directed and random ops against an
// arithmetic reference model, plus handshake, back-to-back and reset scenarios.
module tb_bit_serial_alu_ctrl;
  localparam int W = 24;

  logic         Clock, ResetN, Start;
  logic [W-1:0] A, B;
  logic [2:0]   AluOp;
  logic         Busy, Done, CarryOut, Overflow, Zero;
  logic [W-1:0] Result;

  int errors = 0;
  int checks = 0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .A(A), .B(B), .AluOp(AluOp),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut),
    .Overflow(Overflow), .Zero(Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: returns {carry, overflow, result} from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co, ov;
    r = '0; co = 1'b0; ov = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd4: r = a ^ b;
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0]; co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd3, 3'd5: begin
        s  = {1'b0, a} + {1'b0, ~b} + 25'd1;
        r  = s[W-1:0]; co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        if (op == 3'd5) r = ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
      end
      default: r = '0;
    endcase
    return {co, ov, r};
  endfunction

  task automatic check_reset_state(input string name);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 24'd0 || CarryOut !== 1'b0 ||
        Overflow !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b res=%h co=%b ov=%b z=%b, required 0 0 000000 0 0 1",
               name, Busy, Done, Result, CarryOut, Overflow, Zero);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; A = a; B = b; AluOp = op;
    @(posedge Clock); #1;
    Start = 1'b0; A = W'($urandom); B = W'($urandom); AluOp = 3'($urandom);
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b done=%b, required busy=1 done=0", Busy, Done);
    end
  endtask

  // mode 0: plain; 1: Start held high until Done; 2: Start pulse mid-run with junk operands.
  task automatic wait_check(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int mode, input string name);
    logic [W+1:0] exp;
    bit bad;
    exp = model(op, a, b);
    bad = 1'b0;
    if (mode == 1) Start = 1'b1;
    for (int i = 1; i <= W + 1; i++) begin
      if (mode == 2 && i == 10) begin
        Start = 1'b1; A = W'($urandom); B = W'($urandom); AluOp = 3'($urandom);
      end
      if (mode == 2 && i == 11) Start = 1'b0;
      @(posedge Clock); #1;
      if (i <= W && (Done !== 1'b0 || Busy !== 1'b1)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s busy_window: Done/Busy wrong before edge %0d", name, W + 1);
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b, required 1 0", name, Done, Busy);
    end
    checks++;
    if (Result !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s result: got %h required %h (op=%0d a=%h b=%h)", name, Result, exp[W-1:0], op, a, b);
    end
    checks++;
    if (CarryOut !== exp[W+1] || Overflow !== exp[W]) begin
      errors++;
      $display("FAIL %s flags: co=%b ov=%b required co=%b ov=%b", name, CarryOut, Overflow, exp[W+1], exp[W]);
    end
    checks++;
    if (Zero !== (exp[W-1:0] == 24'd0)) begin
      errors++;
      $display("FAIL %s zero: got %b required %b", name, Zero, (exp[W-1:0] == 24'd0));
    end
    if (mode == 1) Start = 1'b0;
  endtask

  task automatic idle_check(input logic [W-1:0] exp_res, input string name);
    @(posedge Clock); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Result !== exp_res) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b res=%h, required 0 0 %h", name, Done, Busy, Result, exp_res);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode, input string name);
    logic [W+1:0] exp;
    exp = model(op, a, b);
    start_op(op, a, b);
    wait_check(op, a, b, mode, name);
    idle_check(exp[W-1:0], name);
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b0; A = '0; B = '0; AluOp = 3'd0;
    repeat (2) @(posedge Clock);
    #1;
    check_reset_state("reset");
    ResetN = 1'b1;
    @(posedge Clock); #1;
    check_reset_state("post_reset_idle");
  endtask

  task automatic test_arith();
    run_op(3'd2, 24'h7FFFFF, 24'h000001, 0, "add_ovf");
    run_op(3'd3, 24'h000005, 24'h000005, 0, "sub_zero");
    run_op(3'd2, 24'hFFFFFF, 24'h000001, 0, "add_wrap");
    run_op(3'd5, 24'hFFFFFF, 24'h000001, 0, "slt_neg");
    run_op(3'd5, 24'h7FFFFF, 24'h800000, 0, "slt_ovf");
  endtask

  task automatic test_logic();
    run_op(3'd4, 24'hA5A5A5, 24'hFFFF00, 0, "xor");
    run_op(3'd0, 24'hA5A5A5, 24'hFFFF00, 0, "and");
    run_op(3'd1, 24'hA5A5A5, 24'hFFFF00, 0, "or");
    run_op(3'd7, 24'h123456, 24'h654321, 0, "illegal7");
    run_op(3'd6, 24'hFFFFFF, 24'hFFFFFF, 0, "illegal6");
  endtask

  task automatic test_handshake();
    run_op(3'd2, 24'h00F00F, 24'h0F00F0, 1, "start_held");
    run_op(3'd3, 24'h000010, 24'h000020, 2, "start_midrun");
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp;
    start_op(3'd2, 24'h111111, 24'h222222);
    wait_check(3'd2, 24'h111111, 24'h222222, 0, "b2b_first");
    start_op(3'd3, 24'h000001, 24'h000002);
    wait_check(3'd3, 24'h000001, 24'h000002, 0, "b2b_second");
    exp = model(3'd3, 24'h000001, 24'h000002);
    idle_check(exp[W-1:0], "b2b_second");
  endtask

  task automatic test_reset_midop();
    start_op(3'd3, 24'h400000, 24'h000123);
    repeat (11) @(posedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    check_reset_state("reset_midop");
    @(posedge Clock); #1;
    ResetN = 1'b1;
    repeat (W + 3) @(posedge Clock);
    #1;
    check_reset_state("no_done_after_abort");
    run_op(3'd2, 24'h000003, 24'h000004, 0, "add_after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2:0]   op;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = (n % 4 == 0) ? a : W'($urandom);
      if (n % 5 == 1) b = {a[W-1] ^ 1'b1, a[W-2:0]};
      run_op(op, a, b, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that runs one internal 1-bit ALU slice over a WIDTH-bit operand pair, one bit per clock, LSB first. The slice provides AND/OR/XOR/full-add with B-invert and carry-in. This block owns the carry flip-flop, the B-invert/carry-in setup for subtract, the SLT sign fix-up, the flag generation and the Start/Busy/Done handshake. It is the area-reduced alternative to the parallel ALU in the 24-bit CPU's execute stage.

Parameters:
WIDTH, 24, operand/result width in bits (minimum 2).

Ports:
Clock  in  1  single clock; all state updates on the rising edge.
ResetN  in  1  asynchronous active-low reset.
Start  in  1  request; sampled only in IDLE.
A  in  WIDTH  operand A; captured on the accepted Start edge.
B  in  WIDTH  operand B; captured on the accepted Start edge.
AluOp  in  3  operation select: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed); 110/111 illegal.
Busy  out  1  high while an operation is in progress.
Done  out  1  one-cycle pulse; Result and flags are valid from this cycle.
Result  out  WIDTH  registered result; held until the next Done.
CarryOut  out  1  carry out of the MSB for ADD/SUB/SLT; 0 for other ops.
Overflow  out  1  signed overflow for ADD/SUB/SLT; 0 for other ops.
Zero  out  1  high when Result == 0.

Behaviour:
- Reset (async, ResetN=0): state IDLE, Busy=0, Done=0, Result=0, CarryOut=0, Overflow=0, Zero=1. Internal shift registers, bit counter and carry FF are cleared. Reset mid-operation aborts the operation with no Done.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Start=1 at an edge (E0) captures A, B and AluOp into shift registers.
  - Carry FF is loaded with 1 for SUB/SLT and 0 otherwise.
  - Bit counter is set to 0; next state RUN; Busy goes to 1.
- RUN, one bit per edge E1..E_WIDTH:
  - Slice inputs: A[0] and B[0] of the shift registers. BInvert=1 for SUB/SLT. CIN comes from the carry FF.
  - Slice result bit shifts into the MSB of the result shift register; the operand registers shift right.
  - Carry FF takes the slice carry-out.
  - On the MSB cycle, the carry-in to the MSB and the MSB sum bit are additionally stored.
  - After the edge where counter == WIDTH-1, next state is FINISH.
- FINISH (edge E_{WIDTH+1}):
  - Result, flags and Done=1 are registered; Busy=0; next state IDLE.
  - ADD/SUB: Result = shifted sum. CarryOut = final carry. Overflow = carry-into-MSB XOR carry-out-of-MSB.
  - SLT: Result = {WIDTH-1 zeros, MSB-sum XOR Overflow}. CarryOut and Overflow come from the internal subtract.
  - AND/OR/XOR: bitwise result; CarryOut=0, Overflow=0.
  - Illegal op: Result=0, CarryOut=0, Overflow=0. Full latency still applies.
  - Zero = (final Result == 0).
- Latency: Done is high in the cycle after edge E_{WIDTH+1}, i.e. WIDTH+1 edges after the accepting edge, for every op.
- Start while Busy=1 is ignored; no queueing.
- Start high during the Done cycle is accepted (state is already IDLE), giving back-to-back operation with no idle gap.
- Done deasserts on the next edge.
- Result and flags change only at FINISH or reset.
- A and B may change freely after the accepting edge.

Test Plan:
- ADD (WIDTH=24): A=0x7FFFFF, B=0x000001, Start at E0 -> Done high after E25; Result=0x800000, Overflow=1, CarryOut=0, Zero=0; Busy high E0..E25.
- SUB: A=0x000005, B=0x000005 -> Result=0x000000, Zero=1, CarryOut=1, Overflow=0. Then ADD A=0xFFFFFF, B=0x000001 -> Result=0, CarryOut=1, Overflow=0.
- SLT: A=0xFFFFFF, B=0x000001 -> Result=0x000001. Then A=0x7FFFFF, B=0x800000 -> Result=0x000000, Overflow=1.
- Logic ops:
  - XOR A=0xA5A5A5, B=0xFFFF00 -> 0x5A5AA5.
  - AND same operands -> 0xA5A500.
  - OR -> 0xFFFFA5.
  - All with CarryOut=0, Overflow=0.
  - Illegal op 111 -> Result=0, Zero=1 after 25 edges.
- Handshake: Start held high through a whole op -> only one op until Done. Start pulsed at E10 of a running op -> ignored. Start during the Done cycle -> second op begins, Done again 25 edges later.
- Reset: ResetN low at E12 of a SUB -> immediately Busy=0, Done=0, Result=0, Zero=1. After release, a new ADD 3+4 -> Result=0x000007 with normal latency.
